// File: rtl/rename_regfile_pkg.sv
// Shared constants and register-entry type for the rename register file.
package rename_regfile_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);
  localparam int ROB_TAG_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]      value;
    logic                 busy;
    logic [ROB_TAG_W-1:0] tag;
  } rf_entry_t;

endpackage

// File: rtl/rf_read_port.sv
// Combinational operand read port: array lookup, x0 forcing and, when
// RF_COMMIT_BYPASS_EN is defined, same-cycle forwarding of a matching commit.
module rf_read_port
  import rename_regfile_pkg::*;
(
  input  rf_entry_t              regs [NREG],
  input  logic [REG_IDX_W-1:0]   idx,
  input  logic                   rdy,
  input  logic                   clear,
  input  logic                   rn_valid,
  input  logic [REG_IDX_W-1:0]   rn_rd,
  input  logic                   cm_valid,
  input  logic [REG_IDX_W-1:0]   cm_rd,
  input  logic [ROB_TAG_W-1:0]   cm_tag,
  input  logic [XLEN-1:0]        cm_data,
  output logic                   busy,
  output logic [ROB_TAG_W-1:0]   tag,
  output logic [XLEN-1:0]        value
);

  rf_entry_t stored;
  rf_entry_t ent;
  logic      bypass;

  assign stored = regs[idx];

`ifdef RF_COMMIT_BYPASS_EN
  // Forward only a commit that actually releases the rename this cycle;
  // a same-register rename keeps the entry pending.
  assign bypass = rdy && cm_valid && (cm_rd == idx) && stored.busy &&
                  (stored.tag == cm_tag) &&
                  !(rn_valid && (rn_rd == idx) && !clear);
`else
  logic unused_bypass_inputs;
  assign bypass = 1'b0;
  assign unused_bypass_inputs = ^{rdy, clear, rn_valid, rn_rd, cm_valid,
                                  cm_rd, cm_tag, cm_data};
`endif

  always_comb begin
    ent = stored;
    if (bypass) begin
      ent.busy  = 1'b0;
      ent.value = cm_data;
    end
    if (idx == '0) ent = '0;
  end

  assign busy  = ent.busy;
  assign tag   = ent.tag;
  assign value = ent.value;

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register ROB rename tags.
// Optional same-cycle commit forwarding on reads: RF_COMMIT_BYPASS_EN.
module rename_regfile
  import rename_regfile_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   clear,
  input  logic                   rn_valid,
  input  logic [REG_IDX_W-1:0]   rn_rd,
  input  logic [ROB_TAG_W-1:0]   rn_tag,
  input  logic                   cm_valid,
  input  logic [REG_IDX_W-1:0]   cm_rd,
  input  logic [ROB_TAG_W-1:0]   cm_tag,
  input  logic [XLEN-1:0]        cm_data,
  output logic                   cm_busy,
  output logic [ROB_TAG_W-1:0]   cm_reorder,
  input  logic [REG_IDX_W-1:0]   rs1_idx,
  input  logic [REG_IDX_W-1:0]   rs2_idx,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic [ROB_TAG_W-1:0]   rs1_tag,
  output logic [ROB_TAG_W-1:0]   rs2_tag,
  output logic [XLEN-1:0]        rs1_value,
  output logic [XLEN-1:0]        rs2_value
);

  rf_entry_t regs [NREG];

  // Entry 0 is never written after reset, so x0 stays zero in storage too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (rdy) begin
      for (int i = 1; i < NREG; i++) begin
        if (cm_valid && (cm_rd == REG_IDX_W'(i))) regs[i].value <= cm_data;
        // Flush beats rename; rename beats the commit's busy release.
        if (clear) begin
          regs[i].busy <= 1'b0;
          regs[i].tag  <= '0;
        end else if (rn_valid && (rn_rd == REG_IDX_W'(i))) begin
          regs[i].busy <= 1'b1;
          regs[i].tag  <= rn_tag;
        end else if (cm_valid && (cm_rd == REG_IDX_W'(i)) && regs[i].busy &&
                     (regs[i].tag == cm_tag)) begin
          regs[i].busy <= 1'b0;
        end
      end
    end
  end

  assign cm_busy    = regs[cm_rd].busy;
  assign cm_reorder = regs[cm_rd].tag;

  rf_read_port u_rs1 (
    .regs     (regs),
    .idx      (rs1_idx),
    .rdy      (rdy),
    .clear    (clear),
    .rn_valid (rn_valid),
    .rn_rd    (rn_rd),
    .cm_valid (cm_valid),
    .cm_rd    (cm_rd),
    .cm_tag   (cm_tag),
    .cm_data  (cm_data),
    .busy     (rs1_busy),
    .tag      (rs1_tag),
    .value    (rs1_value)
  );

  rf_read_port u_rs2 (
    .regs     (regs),
    .idx      (rs2_idx),
    .rdy      (rdy),
    .clear    (clear),
    .rn_valid (rn_valid),
    .rn_rd    (rn_rd),
    .cm_valid (cm_valid),
    .cm_rd    (cm_rd),
    .cm_tag   (cm_tag),
    .cm_data  (cm_data),
    .busy     (rs2_busy),
    .tag      (rs2_tag),
    .value    (rs2_value)
  );

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed scenarios plus random traffic
// against an array-based reference model, compared every cycle.
module tb_rename_regfile;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        rn_valid;
  logic [4:0]  rn_rd;
  logic [4:0]  rn_tag;
  logic        cm_valid;
  logic [4:0]  cm_rd;
  logic [4:0]  cm_tag;
  logic [31:0] cm_data;
  logic        cm_busy;
  logic [4:0]  cm_reorder;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [4:0]  rs1_tag;
  logic [4:0]  rs2_tag;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;

  rename_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clear      (clear),
    .rn_valid   (rn_valid),
    .rn_rd      (rn_rd),
    .rn_tag     (rn_tag),
    .cm_valid   (cm_valid),
    .cm_rd      (cm_rd),
    .cm_tag     (cm_tag),
    .cm_data    (cm_data),
    .cm_busy    (cm_busy),
    .cm_reorder (cm_reorder),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rs1_tag    (rs1_tag),
    .rs2_tag    (rs2_tag),
    .rs1_value  (rs1_value),
    .rs2_value  (rs2_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors  = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference state: what each architectural register holds.
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [4:0]  m_tag  [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy) begin
      bit release_it;
      release_it = 1'b0;
      if (cm_valid && cm_rd != 0) begin
        release_it = m_busy[cm_rd] && (m_tag[cm_rd] == cm_tag);
        m_val[cm_rd] = cm_data;
      end
      if (clear) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 1'b0; m_tag[i] = '0;
        end
      end else begin
        if (release_it) m_busy[cm_rd] = 1'b0;
        if (rn_valid && rn_rd != 0) begin
          m_busy[rn_rd] = 1'b1; m_tag[rn_rd] = rn_tag;
        end
      end
    end
  end

  task automatic model_read(input logic [4:0] idx, output logic b,
                            output logic [4:0] t, output logic [31:0] v);
    b = m_busy[idx]; t = m_tag[idx]; v = m_val[idx];
`ifdef RF_COMMIT_BYPASS_EN
    if (rdy && cm_valid && cm_rd == idx && m_busy[idx] && m_tag[idx] == cm_tag &&
        !(rn_valid && rn_rd == idx && !clear)) begin
      b = 1'b0; v = cm_data;
    end
`endif
    if (idx == 0) begin
      b = 1'b0; t = '0; v = '0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic        b;
      logic [4:0]  t;
      logic [31:0] v;
      chk("cm_busy", 32'(cm_busy), (cm_rd == 0) ? 32'd0 : 32'(m_busy[cm_rd]));
      chk("cm_reorder", 32'(cm_reorder), (cm_rd == 0) ? 32'd0 : 32'(m_tag[cm_rd]));
      model_read(rs1_idx, b, t, v);
      chk("rs1_busy", 32'(rs1_busy), 32'(b));
      if (!b) chk("rs1_value", rs1_value, v);
      else    chk("rs1_tag", 32'(rs1_tag), 32'(t));
      model_read(rs2_idx, b, t, v);
      chk("rs2_busy", 32'(rs2_busy), 32'(b));
      if (!b) chk("rs2_value", rs2_value, v);
      else    chk("rs2_tag", 32'(rs2_tag), 32'(t));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; clear = 1'b0; rn_valid = 1'b0; cm_valid = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] tg);
    rn_valid = 1'b1; rn_rd = rd; rn_tag = tg;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] tg, input logic [31:0] d);
    cm_valid = 1'b1; cm_rd = rd; cm_tag = tg; cm_data = d;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; clear = 1'b0;
    rn_valid = 1'b0; rn_rd = '0; rn_tag = '0;
    cm_valid = 1'b0; cm_rd = '0; cm_tag = '0; cm_data = '0;
    rs1_idx = 5'd5; rs2_idx = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_rs1_busy", 32'(rs1_busy), 32'd0);
    chk("reset_rs1_value", rs1_value, 32'd0);
    chk("reset_cm_busy", 32'(cm_busy), 32'd0);
    tick();

    // Rename of x0 is ignored
    rename(5'd0, 5'd3); tick();
    idle(); rs1_idx = 5'd0;
    @(negedge clk);
    chk("x0_busy", 32'(rs1_busy), 32'd0);
    chk("x0_value", rs1_value, 32'd0);
    tick();

    // Rename then matching commit
    rename(5'd5, 5'd7); tick();
    idle(); commit(5'd5, 5'd7, 32'hDEAD_BEEF); tick();
    idle(); rs1_idx = 5'd5;
    @(negedge clk);
    chk("commit_busy", 32'(rs1_busy), 32'd0);
    chk("commit_value", rs1_value, 32'hDEAD_BEEF);
    tick();

    // Stale-tag commit writes value but keeps the newer rename
    rename(5'd5, 5'd7); tick();
    rename(5'd5, 5'd9); tick();
    idle(); commit(5'd5, 5'd7, 32'h11); tick();
    idle();
    @(negedge clk);
    chk("stale_value", rs1_value, 32'h11);
    chk("stale_busy", 32'(rs1_busy), 32'd1);
    chk("stale_tag", 32'(rs1_tag), 32'd9);
    tick();

    // Same-cycle commit and rename on one register
    rename(5'd6, 5'd2); tick();
    commit(5'd6, 5'd2, 32'h22); rename(5'd6, 5'd4); tick();
    idle(); rs1_idx = 5'd6;
    @(negedge clk);
    chk("samecyc_value", rs1_value, 32'h22);
    chk("samecyc_busy", 32'(rs1_busy), 32'd1);
    chk("samecyc_tag", 32'(rs1_tag), 32'd4);
    tick();

    // Flush with a commit and a dropped rename
    rename(5'd1, 5'd1); tick();
    rename(5'd2, 5'd2); tick();
    rename(5'd3, 5'd3); tick();
    clear = 1'b1; commit(5'd1, 5'd1, 32'h40); rename(5'd4, 5'd5); tick();
    idle(); rs1_idx = 5'd1; rs2_idx = 5'd2;
    @(negedge clk);
    chk("flush_x1_value", rs1_value, 32'h40);
    chk("flush_x1_busy", 32'(rs1_busy), 32'd0);
    chk("flush_x2_busy", 32'(rs2_busy), 32'd0);
    tick();
    rs1_idx = 5'd3; rs2_idx = 5'd4;
    @(negedge clk);
    chk("flush_x3_busy", 32'(rs1_busy), 32'd0);
    chk("flush_x4_busy", 32'(rs2_busy), 32'd0);
    tick();

    // Commit forwarding visibility in the commit cycle
    rename(5'd8, 5'd1); tick();
    idle(); commit(5'd8, 5'd1, 32'h99); rs1_idx = 5'd8;
    @(negedge clk);
`ifdef RF_COMMIT_BYPASS_EN
    chk("bypass_busy", 32'(rs1_busy), 32'd0);
    chk("bypass_value", rs1_value, 32'h99);
`else
    chk("nobypass_busy", 32'(rs1_busy), 32'd1);
    chk("nobypass_tag", 32'(rs1_tag), 32'd1);
`endif
    chk("bypass_cm_busy", 32'(cm_busy), 32'd1);
    chk("bypass_cm_reorder", 32'(cm_reorder), 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("after_commit_busy", 32'(rs1_busy), 32'd0);
    chk("after_commit_value", rs1_value, 32'h99);
    tick();

    // rdy low freezes everything
    rename(5'd9, 5'd3); tick();
    idle(); rdy = 1'b0; commit(5'd9, 5'd3, 32'h55); rename(5'd10, 5'd6);
    rs1_idx = 5'd9; rs2_idx = 5'd10;
    tick();
    idle();
    @(negedge clk);
    chk("freeze_x9_busy", 32'(rs1_busy), 32'd1);
    chk("freeze_x9_tag", 32'(rs1_tag), 32'd3);
    chk("freeze_x10_busy", 32'(rs2_busy), 32'd0);
    tick();
    rdy = 1'b1; rn_valid = 1'b0; cm_valid = 1'b0;
    @(negedge clk);
    chk("freeze_x9_value", rs1_value, 32'd0);
    chk("freeze_x9_busy_still", 32'(rs1_busy), 32'd1);
    tick();

    // Asynchronous reset mid-cycle
    rename(5'd7, 5'd6); tick();
    idle(); rs1_idx = 5'd7; rs2_idx = 5'd9;
    #2 rst = 1'b0;
    #1;
    chk("async_x7_busy", 32'(rs1_busy), 32'd0);
    chk("async_x7_tag", 32'(rs1_tag), 32'd0);
    chk("async_x9_busy", 32'(rs2_busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      clear    = ($urandom_range(0, 19) == 0);
      rn_valid = $urandom_range(0, 1);
      rn_rd    = 5'($urandom_range(0, 31));
      rn_tag   = 5'($urandom);
      cm_valid = $urandom_range(0, 1);
      cm_rd    = ($urandom_range(0, 3) == 0) ? rn_rd : 5'($urandom_range(0, 31));
      cm_tag   = ($urandom_range(0, 1) == 1) ? m_tag[cm_rd] : 5'($urandom);
      cm_data  = $urandom;
      rs1_idx  = ($urandom_range(0, 2) == 0) ? cm_rd : 5'($urandom_range(0, 31));
      rs2_idx  = ($urandom_range(0, 2) == 0) ? rn_rd : 5'($urandom_range(0, 31));
      tick();
    end
    idle();
    tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Architectural register file with per-register rename tags for the out-of-order core. Sits between dispatch and commit: dispatch renames `rd` to a ROB tag, issue reads operands (value or pending tag), and the ROB commit stage writes results back and releases the rename when the committing tag still owns the register. On a mispredict flush, all renames are discarded and committed values are preserved.

## Interface
- `XLEN`, 32: data width.
- `NREG`, 32: architectural registers; index width is `$clog2(NREG)` (5).
- `TAG_W`, 5: ROB tag width (32-entry ROB).

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rdy` in 1: global enable; low freezes all state.
- `clear` in 1: flush, driven by the ROB mispredict request.
- `rn_valid` in 1: rename request from dispatch.
- `rn_rd` in 5: destination register to rename.
- `rn_tag` in TAG_W: ROB slot allocated to that instruction.
- `cm_valid` in 1: commit write from the ROB.
- `cm_rd` in 5: committing destination register.
- `cm_tag` in TAG_W: ROB slot that is committing.
- `cm_data` in XLEN: committed value.
- `cm_busy` out 1: comb; `busy[cm_rd]`.
- `cm_reorder` out TAG_W: comb; `tag[cm_rd]`.
- `rs1_idx`, `rs2_idx` in 5: operand indices.
- `rs1_busy`, `rs2_busy` out 1: comb; operand is still pending.
- `rs1_tag`, `rs2_tag` out TAG_W: comb; producing ROB slot, valid when busy.
- `rs1_value`, `rs2_value` out XLEN: comb; value, valid when not busy.

## Operation
- State per register: `value[XLEN]`, `busy`, `tag[TAG_W]`.
- Register x0 reads 0 with busy 0. Writes and renames to x0 are ignored.
- Commit (`cm_valid`, `cm_rd`≠0): `value[cm_rd]<=cm_data`. The busy bit is cleared only if `busy[cm_rd] && tag[cm_rd]==cm_tag`. A stale tag writes the value and leaves `busy` and `tag` unchanged.
- Rename (`rn_valid`, `rn_rd`≠0, no `clear`): `busy<=1`, `tag<=rn_tag`.
- Same cycle, same register, rename and commit: the value is written, and the rename wins (busy stays 1, tag becomes `rn_tag`).
- `clear`: all busy bits are cleared and tags are zeroed. A rename in the same cycle is dropped. A commit write in the same cycle is still performed, because a mispredicted JALR commits its link value on the flush cycle.
- `rdy`=0: no state update; combinational outputs still reflect the stored state.
- Read ports: plain array lookup plus the optional bypass (see Configuration). Outputs are always driven, with no X.

## Timing
- Reset (asynchronous assert, synchronous deassert): all values 0, all busy 0, all tags 0. Every output therefore reads 0.
- Reads: zero-latency combinational lookup of current-cycle state.
- Writes, renames and clear: take effect at the next rising edge. Read ports see them in the cycle after.
- A rename in cycle N is visible to reads in cycle N+1. Same-cycle dispatch dependencies are resolved by dispatch, not by this block.
- Reset mid-operation discards all pending renames immediately, with no waiting for `clk`.

## Configuration
- `RF_COMMIT_BYPASS_EN` defined:
  - Condition: `cm_valid`, the read index equals `cm_rd`≠0, `busy` is set and `tag==cm_tag`.
  - Result: the read port returns busy=0 and value=`cm_data` in the same cycle.
  - Suppressed when `rn_valid` targets the same register with no `clear`; the result is then the stored busy and tag.
- Not defined: reads return stored state only. The committed value becomes visible one cycle later.

## Structure
- A shared package holds:
  - constants `XLEN`, `NREG`, `REG_IDX_W`, `ROB_TAG_W`;
  - a struct typedef for a register entry (value, busy, tag).
- One sub-module, `rf_read_port`, is instantiated twice. It contains the combinational lookup, the x0 forcing and the `RF_COMMIT_BYPASS_EN` logic.
- The top level holds the storage array and the write/rename/clear update logic.

## Test plan
- Reset then read x5: `rs1_busy`=0 and `rs1_value`=0. Rename x0 with tag 3, then read x0: busy=0 and value=0.
- Rename x5 with tag 7. Commit x5, tag 7, data 0xDEAD_BEEF. Read x5 next cycle: busy=0 and value=0xDEADBEEF.
- Rename x5 with tag 7, then rename x5 with tag 9. Commit x5, tag 7, data 0x11: value=0x11, busy=1, tag=9.
- Same-cycle commit and rename:
  - Stimulus: x6 renamed with tag 2; commit x6, tag 2, data 0x22 while renaming x6 with tag 4.
  - Result: value 0x22, busy=1, tag=4.
- Flush with commit:
  - Stimulus: rename x1, x2, x3. Then `clear` together with commit x1, data 0x40, and rename x4 with tag 5.
  - Result: all busy=0, x1 reads 0x40, x4 is not busy.
- Bypass and freeze:
  - With `RF_COMMIT_BYPASS_EN`: commit x8, tag 1, data 0x99 while reading x8 gives busy=0 and value=0x99 in the same cycle.
  - Without it: busy=1 that cycle.
  - `rdy`=0 with commit asserted: no change.
  - Asynchronous `rst` pulse mid-cycle: all busy clear immediately.
